// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - RV32I fetch stage assembling four byte reads into one instruction word
// Optional direct-mapped word I-cache is compiled in when IF_ICACHE_EN is defined.
module inst_fetcher #(
   parameter logic [31:0] RESET_PC     = 32'h0,
   parameter int          ICACHE_LINES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en,
   input  logic [31:0] jump_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_pc,
   output logic [31:0] inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [7:0]  mem_rdata
);
   typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n, word_n, hit_word, mem_addr_n;
   logic [2:0]  req_cnt, rsp_cnt, stale_cnt;
   logic [2:0]  req_cnt_n, rsp_cnt_n, stale_n, outstanding;
   logic [3:0]  stale_sum;
   logic        granted, rsp_take, rsp_drop, fill_done, handshake, cache_hit, mem_req_n;

   if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_lines_check
      $error("ICACHE_LINES must be a power of 2");
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (jump_en) begin
         state_n = S_FETCH;
      end else begin
         case (state)
            S_FETCH: if (fill_done || cache_hit) state_n = S_HOLD;
            S_HOLD:  if (handshake) state_n = S_FETCH;
            default: state_n = S_FETCH;
         endcase
      end
   end

   // Responses owed to an abandoned fetch are swallowed before any byte is assembled.
   always_comb begin
      granted     = mem_req & mem_gnt;
      handshake   = inst_valid & inst_ready;
      rsp_drop    = mem_rvalid && (stale_cnt != 3'd0);
      rsp_take    = mem_rvalid && (stale_cnt == 3'd0) && (state == S_FETCH) && (rsp_cnt != 3'd4);
      fill_done   = rsp_take && (rsp_cnt == 3'd3);
      req_cnt_n   = req_cnt + {2'b00, granted};
      rsp_cnt_n   = rsp_cnt + {2'b00, rsp_take};
      word_n      = inst;
      if (rsp_take) word_n[{rsp_cnt[1:0], 3'b000} +: 8] = mem_rdata;
      outstanding = req_cnt_n - rsp_cnt_n;
      stale_sum   = {1'b0, stale_cnt} - {3'b000, rsp_drop} + (jump_en ? {1'b0, outstanding} : 4'd0);
      stale_n     = (stale_sum > 4'd7) ? 3'd7 : stale_sum[2:0];
      if (jump_en)        pc_n = {jump_pc[31:2], 2'b00};
      else if (handshake) pc_n = pc + 32'd4;
      else                pc_n = pc;
      mem_req_n   = (state == S_FETCH) && !jump_en && !cache_hit && (req_cnt_n != 3'd4);
      mem_addr_n  = (state == S_FETCH && !jump_en) ? pc + {29'd0, req_cnt_n} : pc_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc         <= RESET_PC;
         req_cnt    <= 3'd0;
         rsp_cnt    <= 3'd0;
         stale_cnt  <= 3'd0;
         inst_valid <= 1'b0;
         inst       <= 32'd0;
         inst_pc    <= RESET_PC;
         mem_req    <= 1'b0;
         mem_addr   <= 32'd0;
      end else begin
         pc        <= pc_n;
         stale_cnt <= stale_n;
         mem_req   <= mem_req_n;
         mem_addr  <= mem_addr_n;
         if (jump_en) begin
            req_cnt    <= 3'd0;
            rsp_cnt    <= 3'd0;
            inst_valid <= 1'b0;
         end else if (state == S_HOLD) begin
            if (handshake) begin
               inst_valid <= 1'b0;
               req_cnt    <= 3'd0;
               rsp_cnt    <= 3'd0;
            end
         end else if (cache_hit) begin
            inst       <= hit_word;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            req_cnt    <= 3'd4;
            rsp_cnt    <= 3'd4;
         end else begin
            req_cnt <= req_cnt_n;
            rsp_cnt <= rsp_cnt_n;
            inst    <= word_n;
            if (fill_done) begin
               inst_valid <= 1'b1;
               inst_pc    <= pc;
            end
         end
      end
   end

`ifdef IF_ICACHE_EN
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = 30 - IDX_W;

   logic [31:0]             line_data [ICACHE_LINES];
   logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
   logic [ICACHE_LINES-1:0] line_vld;
   logic [IDX_W-1:0]        idx;
   logic [TAG_W-1:0]        tag;
   logic                    first_cycle, fill_wr;

   // Lookup only in the entry cycle: no byte issued yet and nothing granted.
   assign idx         = pc[2 +: IDX_W];
   assign tag         = pc[31 -: TAG_W];
   assign first_cycle = (state == S_FETCH) && (req_cnt == 3'd0) && !mem_req;
   assign cache_hit   = first_cycle && line_vld[idx] && (line_tag[idx] == tag);
   assign hit_word    = line_data[idx];
   assign fill_wr     = fill_done && !jump_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          line_vld      <= '0;
      else if (fill_wr) line_vld[idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (fill_wr) begin
         line_data[idx] <= word_n;
         line_tag[idx]  <= tag;
      end
   end
`else
   assign cache_hit = 1'b0;
   assign hit_word  = 32'd0;
`endif

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed self-checking bench for inst_fetcher
module tb_inst_fetcher;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jump_en = 1'b0;
   logic [31:0] jump_pc = 32'd0;
   logic        inst_ready = 1'b0;
   logic        inst_valid, mem_req, mem_rvalid;
   logic [31:0] inst_pc, inst, mem_addr;
   logic [7:0]  mem_rdata;
   logic        mem_gnt = 1'b1;

   int checks = 0;
   int errors = 0;

`ifdef IF_ICACHE_EN
   localparam int HIT_LAT = 1;
   localparam int HIT_REQ = 0;
`else
   localparam int HIT_LAT = 6;
   localparam int HIT_REQ = 8;
`endif

   always #5 clk = ~clk;

   inst_fetcher #(.RESET_PC(32'h0), .ICACHE_LINES(16)) dut (
      .clk(clk), .rst(rst), .jump_en(jump_en), .jump_pc(jump_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst(inst),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   // Byte memory with a 1- or 2-cycle response pipeline.
   logic [7:0] mem [512];
   int         lat = 1;
   logic       gnt_toggle = 1'b0;
   logic       v1 = 1'b0, v2 = 1'b0;
   logic [7:0] d1 = 8'd0, d2 = 8'd0;

   always @(posedge clk) begin
      v1      <= mem_req & mem_gnt;
      d1      <= mem[mem_addr[8:0]];
      v2      <= v1;
      d2      <= d1;
      mem_gnt <= gnt_toggle ? ~mem_gnt : 1'b1;
   end
   assign mem_rvalid = (lat == 2) ? v2 : v1;
   assign mem_rdata  = (lat == 2) ? d2 : d1;

   int          hs_cnt = 0;
   int          req_cycles = 0;
   logic [31:0] gnt_log [$];

   always @(posedge clk) begin
      if (inst_valid && inst_ready) hs_cnt <= hs_cnt + 1;
      if (mem_req) req_cycles <= req_cycles + 1;
      if (mem_req && mem_gnt) gnt_log.push_back(mem_addr);
   end

   task automatic wait_valid(output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end while (!inst_valid && cycles < 40);
   endtask

   task automatic accept();
      inst_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inst_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
      checks++; if (inst !== 32'd0) begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
      checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
      checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
   endtask

   task automatic test_first_fetch();
      int cyc;
      int base;
      base = gnt_log.size();
      rst = 1'b0;
      wait_valid(cyc);
      checks++; if (cyc != 6) begin errors++; $display("FAIL first_latency got %0d want 6", cyc); end
      checks++; if (inst !== 32'h00100513) begin errors++; $display("FAIL first_inst got %h want 00100513", inst); end
      checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL first_inst_pc got %h want 0", inst_pc); end
      checks++;
      if (gnt_log.size() != base + 4 || gnt_log[base] !== 32'd0 || gnt_log[base+1] !== 32'd1 ||
          gnt_log[base+2] !== 32'd2 || gnt_log[base+3] !== 32'd3) begin
         errors++; $display("FAIL first_addr_seq got %0d grants want 0,1,2,3", gnt_log.size() - base);
      end
   endtask

   task automatic test_hold_ready();
      int cyc;
      int base;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (inst_valid !== 1'b1 || inst !== 32'h00100513 || inst_pc !== 32'h0) begin
            errors++; $display("FAIL hold_stable got v=%b inst=%h pc=%h want 1 00100513 0", inst_valid, inst, inst_pc);
         end
         checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL hold_mem_req got %b want 0", mem_req); end
      end
      base = gnt_log.size();
      accept();
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL hold_drop_valid got %b want 0", inst_valid); end
      wait_valid(cyc);
      checks++; if (cyc != 6) begin errors++; $display("FAIL next_latency got %0d want 6", cyc); end
      checks++; if (inst_pc !== 32'h4) begin errors++; $display("FAIL next_inst_pc got %h want 4", inst_pc); end
      checks++; if (inst !== 32'h00200593) begin errors++; $display("FAIL next_inst got %h want 00200593", inst); end
      checks++;
      if (gnt_log.size() <= base || gnt_log[base] !== 32'h4) begin
         errors++; $display("FAIL next_first_addr got %0d grants want first addr 4", gnt_log.size() - base);
      end
   endtask

   task automatic test_gnt_toggle();
      int          cyc;
      int          base;
      int          held;
      logic        prev_req, prev_gnt;
      logic [31:0] prev_addr;
      gnt_toggle = 1'b1;
      base = gnt_log.size();
      accept();
      held = 0;
      cyc = 0;
      prev_req = mem_req; prev_gnt = mem_gnt; prev_addr = mem_addr;
      while (!inst_valid && cyc < 60) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (prev_req && !prev_gnt) begin
            held++;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
               errors++; $display("FAIL gnt_hold got req=%b addr=%h want 1 %h", mem_req, mem_addr, prev_addr);
            end
         end
         prev_req = mem_req; prev_gnt = mem_gnt; prev_addr = mem_addr;
      end
      gnt_toggle = 1'b0;
      checks++; if (held == 0) begin errors++; $display("FAIL gnt_hold_seen got 0 want >0"); end
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL toggle_valid got %b want 1", inst_valid); end
      checks++; if (inst_pc !== 32'h8) begin errors++; $display("FAIL toggle_inst_pc got %h want 8", inst_pc); end
      checks++; if (inst !== 32'h00300613) begin errors++; $display("FAIL toggle_inst got %h want 00300613", inst); end
      checks++;
      if (gnt_log.size() != base + 4 || gnt_log[base] !== 32'd8 || gnt_log[base+1] !== 32'd9 ||
          gnt_log[base+2] !== 32'd10 || gnt_log[base+3] !== 32'd11) begin
         errors++; $display("FAIL toggle_addr_seq got %0d grants want 8,9,10,11", gnt_log.size() - base);
      end
   endtask

   task automatic test_redirect_stale();
      int cyc;
      int base;
      lat = 2;
      accept();
      cyc = 0;
      while (!(mem_req && mem_gnt) && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'd13) begin
         errors++; $display("FAIL redirect_setup got req=%b addr=%h want 1 0000000d", mem_req, mem_addr);
      end
      jump_en = 1'b1;
      jump_pc = 32'h103;
      @(negedge clk);
      jump_en = 1'b0;
      base = gnt_log.size();
      checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL redirect_addr got %h want 100", mem_addr); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redirect_valid got %b want 0", inst_valid); end
      wait_valid(cyc);
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL redirect_done got %b want 1", inst_valid); end
      checks++; if (inst_pc !== 32'h100) begin errors++; $display("FAIL redirect_inst_pc got %h want 100", inst_pc); end
      checks++; if (inst !== 32'h12345678) begin errors++; $display("FAIL redirect_inst got %h want 12345678", inst); end
      checks++;
      if (gnt_log.size() != base + 4 || gnt_log[base] !== 32'h100 || gnt_log[base+3] !== 32'h103) begin
         errors++; $display("FAIL redirect_addr_seq got %0d grants want 100..103", gnt_log.size() - base);
      end
   endtask

   task automatic test_jump_handshake();
      int cyc;
      int base;
      int hs0;
      lat = 1;
      accept();
      wait_valid(cyc);
      checks++; if (inst_pc !== 32'h104) begin errors++; $display("FAIL jh_pre_pc got %h want 104", inst_pc); end
      checks++; if (inst !== 32'h00000013) begin errors++; $display("FAIL jh_pre_inst got %h want 00000013", inst); end
      hs0 = hs_cnt;
      base = gnt_log.size();
      inst_ready = 1'b1;
      jump_en = 1'b1;
      jump_pc = 32'h40;
      @(posedge clk);
      @(negedge clk);
      inst_ready = 1'b0;
      jump_en = 1'b0;
      checks++; if (hs_cnt - hs0 != 1) begin errors++; $display("FAIL jh_transfers got %0d want 1", hs_cnt - hs0); end
      checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL jh_valid got %b want 0", inst_valid); end
      wait_valid(cyc);
      checks++; if (cyc != 6) begin errors++; $display("FAIL jh_latency got %0d want 6", cyc); end
      checks++; if (inst_pc !== 32'h40) begin errors++; $display("FAIL jh_inst_pc got %h want 40", inst_pc); end
      checks++; if (inst !== 32'hdeadbeef) begin errors++; $display("FAIL jh_inst got %h want deadbeef", inst); end
      checks++;
      if (gnt_log.size() <= base || gnt_log[base] !== 32'h40) begin
         errors++; $display("FAIL jh_first_addr got %0d grants want first addr 40", gnt_log.size() - base);
      end
   endtask

   task automatic test_loop();
      int cyc;
      int r0;
      int exp_lat;
      int exp_req;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL loop_reset got v=%b req=%b want 0 0", inst_valid, mem_req); end
      rst = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         exp_lat = (pass == 0) ? 6 : HIT_LAT;
         exp_req = (pass == 0) ? 8 : HIT_REQ;
         r0 = req_cycles;
         wait_valid(cyc);
         checks++; if (cyc != exp_lat) begin errors++; $display("FAIL loop%0d_lat0 got %0d want %0d", pass, cyc, exp_lat); end
         checks++;
         if (inst_pc !== 32'h0 || inst !== 32'h00100513) begin
            errors++; $display("FAIL loop%0d_word0 got %h %h want 0 00100513", pass, inst_pc, inst);
         end
         accept();
         wait_valid(cyc);
         checks++; if (cyc != exp_lat) begin errors++; $display("FAIL loop%0d_lat4 got %0d want %0d", pass, cyc, exp_lat); end
         checks++;
         if (inst_pc !== 32'h4 || inst !== 32'h00200593) begin
            errors++; $display("FAIL loop%0d_word4 got %h %h want 4 00200593", pass, inst_pc, inst);
         end
         inst_ready = 1'b1;
         jump_en = 1'b1;
         jump_pc = 32'h0;
         @(posedge clk);
         @(negedge clk);
         inst_ready = 1'b0;
         jump_en = 1'b0;
         checks++;
         if (req_cycles - r0 != exp_req) begin
            errors++; $display("FAIL loop%0d_req_cycles got %0d want %0d", pass, req_cycles - r0, exp_req);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'hff;
      {mem[3], mem[2], mem[1], mem[0]}                 = 32'h00100513;
      {mem[7], mem[6], mem[5], mem[4]}                 = 32'h00200593;
      {mem[11], mem[10], mem[9], mem[8]}               = 32'h00300613;
      {mem[15], mem[14], mem[13], mem[12]}             = 32'hddccbbaa;
      {mem[67], mem[66], mem[65], mem[64]}             = 32'hdeadbeef;
      {mem[259], mem[258], mem[257], mem[256]}         = 32'h12345678;
      {mem[263], mem[262], mem[261], mem[260]}         = 32'h00000013;
      test_reset();
      test_first_fetch();
      test_hold_ready();
      test_gnt_toggle();
      test_redirect_stale();
      test_jump_handshake();
      test_loop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
